onchip_mem_arbiter: RTL and testbench

- Shares the single-port 32K x 32 on-chip RAM (1-cycle read latency: registered address, unregistered q) between two Avalon-MM pipelined masters.
  - m0 is the CPU data master.
  - m1 is the camera frame DMA.
- Issues at most one transfer per cycle.
- Arbitration is round-robin with a bounded hold, so a streaming master cannot starve the other.
- Returns read data with readdatavalid exactly one cycle after acceptance.

---
 rtl/onchip_mem_arbiter_pkg.sv | 20 ++
 rtl/onchip_mem_arbiter_if.sv | 30 +++
 rtl/rr_hold_arbiter.sv | 66 ++++++
 rtl/onchip_mem_arbiter.sv | 109 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pkg
// Shared constants and types for the on-chip RAM arbiter slice.
//   ADDR_W : word address width of the 32K x 32 RAM
//   DATA_W : data width
//   BE_W   : byteenable width (one bit per byte lane)
//   owner_t: identifies which master owns / wins the RAM port
// ---------------------------------------------------------------------------
package onchip_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
// One Avalon-MM pipelined master port as seen by the arbiter.
//   master modport: drives address/byteenable/read/write/writedata,
//                   receives waitrequest/readdata/readdatavalid
//   slave modport : the mirror image, used by onchip_mem_arbiter
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if;
    import onchip_mem_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
// Two-way round-robin arbiter with a bounded hold. The current owner keeps
// the grant while both request, until it has had MAX_HOLD consecutive
// accepts; then the other master is granted.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request per master (bit 0 = m0, bit 1 = m1)
//   accept       : the granted request was taken this cycle
//   gnt[1:0]     : combinational one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_hold_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    owner_t           last_owner;
    logic [CNT_W-1:0] hold_cnt;
    owner_t           winner;

    // Under contention the owner keeps the port until its hold budget is used.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (hold_cnt < HOLD_LIM)
                    gnt = (last_owner == OWN_M1) ? 2'b10 : 2'b01;
                else
                    gnt = (last_owner == OWN_M1) ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    assign winner = gnt[1] ? OWN_M1 : OWN_M0;

    // hold_cnt saturates at MAX_HOLD; an idle cycle forgets the streak.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_M0;
            hold_cnt   <= '0;
        end else if (accept) begin
            if (winner == last_owner) begin
                if (hold_cnt != HOLD_LIM)
                    hold_cnt <= hold_cnt + CNT_W'(1);
            end else begin
                last_owner <= winner;
                hold_cnt   <= CNT_W'(1);
            end
        end else if (req == 2'b00) begin
            hold_cnt <= '0;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares a single-port 32K x 32 on-chip RAM (registered address, q valid the
// cycle after acceptance) between two Avalon-MM pipelined masters: m0 (CPU
// data master) and m1 (camera frame DMA). One transfer per cycle, owner
// switches cost no bubble, read data returns exactly one cycle after accept.
//   clk, reset_n   : clock, asynchronous active-low reset
//   m0, m1         : Avalon-MM slave-side ports (onchip_mem_arbiter_if.slave)
//   mem_address    : RAM word address
//   mem_byteenable : RAM byte lanes
//   mem_chipselect : RAM access this cycle
//   mem_write      : RAM write (read when chipselect without write)
//   mem_writedata  : RAM write data
//   mem_readdata   : RAM q, valid the cycle after a read accept
// ---------------------------------------------------------------------------
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic       ready;
    logic [1:0] req;
    logic [1:0] req_live;
    logic [1:0] gnt;
    logic       accept;
    owner_t     winner;
    logic       win_write;
    logic       rdv_q;
    owner_t     rdv_sel;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    // Requests are hidden from the arbiter until the first edge after reset,
    // so nothing is granted while ready is low.
    assign req_live = ready ? req : 2'b00;

    rr_hold_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_live),
        .accept  (accept),
        .gnt     (gnt)
    );

    assign accept = |(req_live & gnt);
    assign winner = gnt[1] ? OWN_M1 : OWN_M0;

    assign m0.waitrequest = ~(ready & gnt[0]);
    assign m1.waitrequest = ~(ready & gnt[1]);

    // RAM-side mux; with no accept it rests on m0, which the RAM ignores
    // because chipselect is low.
    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        win_write      = m0.write;
        if (winner == OWN_M1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            win_write      = m1.write;
        end
    end

    // Read+write together counts as a write, so it never returns data.
    assign mem_chipselect = accept;
    assign mem_write      = accept & win_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    // One-deep return pipe: q shows up one cycle after the read is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_q   <= 1'b0;
            rdv_sel <= OWN_M0;
        end else begin
            rdv_q <= accept & ~win_write;
            if (accept & ~win_write)
                rdv_sel <= winner;
        end
    end

    assign m0.readdatavalid = rdv_q & (rdv_sel == OWN_M0);
    assign m1.readdatavalid = rdv_q & (rdv_sel == OWN_M1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Directed bench for onchip_mem_arbiter. dut_a (MAX_HOLD=8) drives a simple
// RAM in the bench and is tracked by a transaction-level model every cycle;
// dut_b (MAX_HOLD=1) is used for the strict-alternation case.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int MODEL_HOLD = 8;

    logic clk;
    logic reset_n;

    onchip_mem_arbiter_if m0_bus ();
    onchip_mem_arbiter_if m1_bus ();
    onchip_mem_arbiter_if b0_bus ();
    onchip_mem_arbiter_if b1_bus ();

    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [14:0] b_mem_address;
    logic [3:0]  b_mem_byteenable;
    logic        b_mem_chipselect;
    logic        b_mem_write;
    logic [31:0] b_mem_writedata;
    logic [31:0] b_mem_readdata;

    int vectors;
    int miscompares;

    onchip_mem_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    onchip_mem_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (b0_bus),
        .m1             (b1_bus),
        .mem_address    (b_mem_address),
        .mem_byteenable (b_mem_byteenable),
        .mem_chipselect (b_mem_chipselect),
        .mem_write      (b_mem_write),
        .mem_writedata  (b_mem_writedata),
        .mem_readdata   (b_mem_readdata)
    );

    assign b_mem_readdata = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM seen by dut_a: registered read address, unregistered q.
    logic [31:0] ram     [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [14:0] ram_addr_q;

    initial begin
        ram_addr_q = '0;
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 32'h9E37_79B1 * i;
            ref_mem[i] = 32'h9E37_79B1 * i;
        end
    end

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_addr_q <= mem_address;
            end
        end
    end

    assign mem_readdata = ram[ram_addr_q];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int master, input logic rd, input logic wr,
                                 input logic [14:0] addr, input logic [3:0] be,
                                 input logic [31:0] data);
        if (master == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
            m0_bus.byteenable = be; m0_bus.writedata = data;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
            m1_bus.byteenable = be; m1_bus.writedata = data;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who should win this cycle, and which read
    // (master, data) is due back, tracked with integers and a word array.
    int          mdl_ready, mdl_last, mdl_hold;
    int          pend_valid, pend_m;
    logic [31:0] pend_data;
    int          g;
    logic        rq0, rq1, w;
    logic [14:0] a;
    logic [3:0]  be;
    logic [31:0] d;

    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("reset_wait_m0", {31'b0, m0_bus.waitrequest}, 1);
            checkOutput("reset_wait_m1", {31'b0, m1_bus.waitrequest}, 1);
            checkOutput("reset_rdv_m0", {31'b0, m0_bus.readdatavalid}, 0);
            checkOutput("reset_rdv_m1", {31'b0, m1_bus.readdatavalid}, 0);
            checkOutput("reset_chipselect", {31'b0, mem_chipselect}, 0);
            mdl_ready = 0; mdl_last = 0; mdl_hold = 0; pend_valid = 0; pend_m = 0;
        end else begin
            rq0 = m0_bus.read | m0_bus.write;
            rq1 = m1_bus.read | m1_bus.write;
            g = -1;
            if (mdl_ready != 0) begin
                if (rq0 && rq1) g = (mdl_hold < MODEL_HOLD) ? mdl_last : 1 - mdl_last;
                else if (rq0) g = 0;
                else if (rq1) g = 1;
            end
            checkOutput("wait_m0", {31'b0, m0_bus.waitrequest}, {31'b0, g != 0});
            checkOutput("wait_m1", {31'b0, m1_bus.waitrequest}, {31'b0, g != 1});
            checkOutput("chipselect", {31'b0, mem_chipselect}, {31'b0, g >= 0});
            w = 1'b0; a = '0; be = '0; d = '0;
            if (g >= 0) begin
                if (g == 0) begin
                    w = m0_bus.write; a = m0_bus.address; be = m0_bus.byteenable; d = m0_bus.writedata;
                end else begin
                    w = m1_bus.write; a = m1_bus.address; be = m1_bus.byteenable; d = m1_bus.writedata;
                end
                checkOutput("mem_write", {31'b0, mem_write}, {31'b0, w});
                checkOutput("mem_address", {17'b0, mem_address}, {17'b0, a});
                if (w) begin
                    checkOutput("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, be});
                    checkOutput("mem_writedata", mem_writedata, d);
                end
            end else begin
                checkOutput("mem_write_idle", {31'b0, mem_write}, 0);
            end
            checkOutput("rdv_m0", {31'b0, m0_bus.readdatavalid}, {31'b0, pend_valid != 0 && pend_m == 0});
            checkOutput("rdv_m1", {31'b0, m1_bus.readdatavalid}, {31'b0, pend_valid != 0 && pend_m == 1});
            if (pend_valid != 0)
                checkOutput(pend_m == 0 ? "rdata_m0" : "rdata_m1",
                            pend_m == 0 ? m0_bus.readdata : m1_bus.readdata, pend_data);
            pend_valid = (g >= 0 && !w) ? 1 : 0;
            if (pend_valid != 0) begin
                pend_m    = g;
                pend_data = ref_mem[a];
            end
            if (g >= 0 && w)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            if (g >= 0) begin
                if (g == mdl_last) mdl_hold = (mdl_hold < MODEL_HOLD) ? mdl_hold + 1 : MODEL_HOLD;
                else begin mdl_last = g; mdl_hold = 1; end
            end else if (!rq0 && !rq1) begin
                mdl_hold = 0;
            end
            mdl_ready = 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    int grant_log [0:31];
    int both_low;
    int sg;

    initial begin
        vectors = 0; miscompares = 0; both_low = 0;
        reset_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 15'h0000, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 15'h0000, 4'hF, 32'h0);
        b0_bus.read = 1'b0; b0_bus.write = 1'b0; b0_bus.address = '0; b0_bus.byteenable = 4'hF; b0_bus.writedata = '0;
        b1_bus.read = 1'b0; b1_bus.write = 1'b0; b1_bus.address = '0; b1_bus.byteenable = 4'hF; b1_bus.writedata = '0;

        // Reset with m0 already requesting; first accept lands 2 edges after release.
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first_cycle_wait_m0", {31'b0, m0_bus.waitrequest}, 1);
        @(negedge clk);
        checkOutput("second_cycle_wait_m0", {31'b0, m0_bus.waitrequest}, 0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 15'h0000, 4'hF, 32'h0);
        stepCycle();

        // Single master write then read-back.
        applyStimulus(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("single_rdv_m0", {31'b0, m0_bus.readdatavalid}, 1);
        checkOutput("single_rdata_m0", m0_bus.readdata, 32'hDEADBEEF);
        checkOutput("single_rdv_m1", {31'b0, m1_bus.readdatavalid}, 0);
        stepCycle();

        // Byte lanes at the top address.
        applyStimulus(0, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'h11223344);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b1, 15'h7FFF, 4'h2, 32'hAABBCCDD);
        stepCycle();
        applyStimulus(0, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 15'h0000, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("bytelane_rdata", m0_bus.readdata, 32'h1122CC44);
        stepCycle();

        // Both masters stream reads: bursts of 8 alternate m0, m1, m0.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 15'h0100 + 15'(i), 4'hF, 32'h0);
            applyStimulus(1, 1'b1, 1'b0, 15'h0200 + 15'(i), 4'hF, 32'h0);
            @(negedge clk);
            grant_log[i] = !m0_bus.waitrequest ? 0 : (!m1_bus.waitrequest ? 1 : -1);
            if (!m0_bus.waitrequest && !m1_bus.waitrequest) both_low++;
            stepCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        for (int i = 0; i < 24; i++)
            checkOutput($sformatf("contention_grant_%0d", i), grant_log[i], (i / 8) % 2);
        checkOutput("contention_both_granted", both_low, 0);
        stepCycle();

        // m0 alone saturates its hold; m1 then wins immediately.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 15'h0300 + 15'(i), 4'hF, 32'h0);
            stepCycle();
        end
        applyStimulus(1, 1'b1, 1'b0, 15'h0400, 4'hF, 32'h0);
        @(negedge clk);
        sg = !m0_bus.waitrequest ? 0 : (!m1_bus.waitrequest ? 1 : -1);
        checkOutput("saturated_hold_grant", sg, 1);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        stepCycle();

        // An idle cycle clears the streak, so a short m0 burst keeps the port.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 15'h0500 + 15'(i), 4'hF, 32'h0);
            stepCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 15'h0600 + 15'(i), 4'hF, 32'h0);
            stepCycle();
        end
        applyStimulus(1, 1'b1, 1'b0, 15'h0700, 4'hF, 32'h0);
        @(negedge clk);
        sg = !m0_bus.waitrequest ? 0 : (!m1_bus.waitrequest ? 1 : -1);
        checkOutput("idle_reset_hold_grant", sg, 0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
        stepCycle();

        // MAX_HOLD=1 instance: strict alternation starting with m0.
        b0_bus.read = 1'b1; b1_bus.read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sg = !b0_bus.waitrequest ? 0 : (!b1_bus.waitrequest ? 1 : -1);
            checkOutput($sformatf("alternate_grant_%0d", i), sg, i % 2);
            stepCycle();
        end
        b0_bus.read = 1'b0; b1_bus.read = 1'b0;
        stepCycle();

        // Reset right after an m1 read accept drops that read's return.
        applyStimulus(1, 1'b0, 1'b1, 15'h0055, 4'hF, 32'hCAFEF00D);
        stepCycle();
        applyStimulus(1, 1'b1, 1'b0, 15'h0055, 4'hF, 32'h0);
        stepCycle();
        reset_n = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 15'h0055, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("midreset_rdv_m1", {31'b0, m1_bus.readdatavalid}, 0);
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        applyStimulus(1, 1'b1, 1'b0, 15'h0055, 4'hF, 32'h0);
        stepCycle();
        applyStimulus(1, 1'b0, 1'b0, 15'h0055, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("reread_rdv_m1", {31'b0, m1_bus.readdatavalid}, 1);
        checkOutput("reread_rdata_m1", m1_bus.readdata, 32'hCAFEF00D);
        stepCycle();
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
